pwm_channel_controller: RTL
===========================

# pwm_channel_controller

Drives the eight PWM-capable outputs from the configuration registers written over SPI. Contains two PWM generators, each with a programmable power-of-two prescaler and two duty-cycle compare channels. Per-output routing, PWM/static selection and enable come from the register file. Duty and divider updates apply only at generator period boundaries, so outputs never glitch. Sits between the SPI register block and the chip output pads.

## Interface
Parameters:
- CNT_W, 8: PWM period counter width; period is 2^CNT_W ticks.
- DIV_W, 4: width of each generator's divider field.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- reg_en_out  in  8  per-output enable.
- reg_en_pwm_out  in  8  per-output mode: 1 = PWM, 0 = static high.
- reg_out_3_0_pwm_gen_channel  in  8  source select for outputs 3..0; output i uses bits [2i+1:2i].
- reg_out_7_4_pwm_gen_channel  in  8  source select for outputs 7..4; output i+4 uses bits [2i+1:2i].
- reg_pwm_gen_0_ch_0_duty_cycle, reg_pwm_gen_0_ch_1_duty_cycle, reg_pwm_gen_1_ch_0_duty_cycle, reg_pwm_gen_1_ch_1_duty_cycle  in  8 each  requested duty.
- reg_pwm_gen_1_0_frequency_divider  in  8  [3:0] = gen0 divider d0, [7:4] = gen1 divider d1.
- pwm_out  out  8  registered output pins.
- period_start  out  2  one-cycle pulse per generator when its counter is 0 after a wrap.

## Operation
- **Source select encoding** (2-bit field): 00 = gen0 ch0, 01 = gen0 ch1, 10 = gen1 ch0, 11 = gen1 ch1.
- **Prescaler**, per generator: free-running counter of width 2^DIV_W−1 bits. It asserts tick when the count equals 2^d_act−1, then restarts from 0. For d_act = 0, tick is asserted every cycle.
- **Period counter**, per generator: CNT_W-bit counter that increments on tick and wraps 255→0.
- **Wrap** (tick with cnt = 255) does the following:
  - loads the active duty registers for both channels and d_act from the reg_* inputs;
  - clears the prescaler;
  - sets period_start in the next cycle.
- **Initial load:** an init flag is set by rst. In the first cycle after rst deasserts, all active registers load from the inputs, counters and prescalers are cleared, and period_start pulses.
- **Compare:** channel level = (cnt < duty_act). Duty 0 gives constant low; duty 255 gives high for 255/256 of the period.
- **Output:**
  - pwm_out[i] = 0 if reg_en_out[i] = 0;
  - else 1 if reg_en_pwm_out[i] = 0;
  - else the level of the selected channel.
- **Immediate vs deferred inputs:**
  - en, mode and select inputs take effect immediately (no shadowing).
  - Duty and divider inputs are shadowed until the next wrap.
- **Mid-period changes:** a duty or divider write mid-period is ignored until the wrap. Multiple writes within one period mean only the value present at the wrap applies.
- **Reset:** asserting rst at any point zeroes all state and outputs on that edge. There is no partial state.
- **Independence:** the two generators are independent. Simultaneous wraps need no interaction.

## Timing
- **Reset values:** pwm_out = 0, period_start = 0, all counters/prescalers = 0, all active duty and divider registers = 0.
- **Output latency:** pwm_out is registered, so it lags the internal compare by 1 clk. A change of en/mode/select shows on pwm_out 1 clk after the input changes.
- **Period:** 256 × 2^d_act clk cycles. High time is duty_act × 2^d_act clk cycles.
- **period_start alignment:** asserted in the cycle where cnt = 0 immediately after a wrap or initial load. The first PWM-high cycle of that period appears on pwm_out 1 clk later.

## Structure
- **Shared package:** CNT_W, DIV_W, and the source-select encoding constants (SEL_G0C0..SEL_G1C1).
- **Sub-module pwm_gen:** instantiated twice. Contains the prescaler, period counter, shadow/active duty and divider registers, two comparators and the period_start pulse. The top level adds the 8-way output mux and the output register.
- **Target size:** roughly 200 lines of RTL.

## Test plan
- **Basic PWM:** d0 = 0, gen0 ch0 duty = 64, out0 sel = 00, en_out = en_pwm = 0x01 → pwm_out[0] high 64 clk out of every 256. period_start[0] pulses every 256 clk.
- **Divider:** d1 = 2, gen1 ch1 duty = 128, out7 sel = 11 → period 1024 clk, high 512 clk, repeating.
- **Shadowing:** change gen0 ch0 duty 64→200 at cnt = 100 → current period stays at 64 high; the next period is 200 high. Same check for a divider change.
- **Static/disable/select:** en_pwm[3] = 0 with en_out[3] = 1 → pwm_out[3] = 1 one clk later. en_out[3] = 0 → 0 one clk later. Changing a select mid-period switches the source 1 clk later.
- **Duty boundaries:** duty 0 → output never high. Duty 255 → high for 255 cycles, low for 1 per period (d = 0).
- **Reset:** assert rst mid-period → all outputs 0 on the next edge. After release, the new register values apply from the first cycle and period_start pulses once.

Source files
------------

// File: rtl/pwm_channel_controller_pkg.sv
// Shared constants for the PWM channel controller: counter widths and the
// 2-bit output source-select encoding.
package pwm_channel_controller_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIV_W = 4;

    localparam logic [1:0] SEL_G0C0 = 2'b00;
    localparam logic [1:0] SEL_G0C1 = 2'b01;
    localparam logic [1:0] SEL_G1C0 = 2'b10;
    localparam logic [1:0] SEL_G1C1 = 2'b11;

endpackage

// File: rtl/pwm_channel_controller_pwm_gen.sv
// One PWM generator: power-of-two prescaler, period counter, two compare channels.
// Duty and divider values are shadowed and only taken at period wrap or initial load.
module pwm_channel_controller_pwm_gen
    import pwm_channel_controller_pkg::*;
#(
    parameter int unsigned CNT_W = pwm_channel_controller_pkg::CNT_W,
    parameter int unsigned DIV_W = pwm_channel_controller_pkg::DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_duty0,
    input  logic [CNT_W-1:0] i_duty1,
    input  logic [DIV_W-1:0] i_div,
    output logic [1:0]       o_level,
    output logic             o_period_start
);

    localparam int unsigned PS_W = (2 ** DIV_W) - 1;
    localparam logic [PS_W:0]    PS_ONE  = {{PS_W{1'b0}}, 1'b1};
    localparam logic [PS_W-1:0]  PS_INC  = {{(PS_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W - 1){1'b0}}, 1'b1};

    logic [PS_W-1:0]  r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_duty0;
    logic [CNT_W-1:0] r_duty1;
    logic [DIV_W-1:0] r_div;
    logic             r_init;
    logic             r_period_start;

    logic [PS_W:0] w_limit;
    logic          w_tick;
    logic          w_wrap;

    // Prescaler terminal count is 2^div - 1; one extra bit keeps div = max exact.
    assign w_limit = PS_ONE << r_div;
    assign w_tick  = ({1'b0, r_presc} == (w_limit - PS_ONE));
    assign w_wrap  = w_tick & (&r_cnt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            r_duty0        <= '0;
            r_duty1        <= '0;
            r_div          <= '0;
            r_init         <= 1'b1;
            r_period_start <= 1'b0;
        end else if (r_init) begin
            r_init         <= 1'b0;
            r_presc        <= '0;
            r_cnt          <= '0;
            r_duty0        <= i_duty0;
            r_duty1        <= i_duty1;
            r_div          <= i_div;
            r_period_start <= 1'b1;
        end else begin
            r_period_start <= w_wrap;
            if (w_tick) begin
                r_presc <= '0;
                r_cnt   <= r_cnt + CNT_INC;
                if (w_wrap) begin
                    r_duty0 <= i_duty0;
                    r_duty1 <= i_duty1;
                    r_div   <= i_div;
                end
            end else begin
                r_presc <= r_presc + PS_INC;
            end
        end
    end

    assign o_level        = {(r_cnt < r_duty1), (r_cnt < r_duty0)};
    assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_channel_controller.sv
// Eight registered PWM/static output pins fed from two PWM generators.
// Enable, mode and source select act immediately; duty/divider go through the generators.
module pwm_channel_controller
    import pwm_channel_controller_pkg::*;
#(
    parameter int unsigned CNT_W = pwm_channel_controller_pkg::CNT_W,
    parameter int unsigned DIV_W = pwm_channel_controller_pkg::DIV_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         reg_en_out,
    input  logic [7:0]         reg_en_pwm_out,
    input  logic [7:0]         reg_out_3_0_pwm_gen_channel,
    input  logic [7:0]         reg_out_7_4_pwm_gen_channel,
    input  logic [CNT_W-1:0]   reg_pwm_gen_0_ch_0_duty_cycle,
    input  logic [CNT_W-1:0]   reg_pwm_gen_0_ch_1_duty_cycle,
    input  logic [CNT_W-1:0]   reg_pwm_gen_1_ch_0_duty_cycle,
    input  logic [CNT_W-1:0]   reg_pwm_gen_1_ch_1_duty_cycle,
    input  logic [2*DIV_W-1:0] reg_pwm_gen_1_0_frequency_divider,
    output logic [7:0]         pwm_out,
    output logic [1:0]         period_start
);

    // Channel levels in select-code order: {g1c1, g1c0, g0c1, g0c0}.
    logic [3:0]  w_level;
    logic [15:0] w_sel_all;
    logic [7:0]  w_pwm_d;

    pwm_channel_controller_pwm_gen #(
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) u_gen0 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_duty0        (reg_pwm_gen_0_ch_0_duty_cycle),
        .i_duty1        (reg_pwm_gen_0_ch_1_duty_cycle),
        .i_div          (reg_pwm_gen_1_0_frequency_divider[DIV_W-1:0]),
        .o_level        (w_level[1:0]),
        .o_period_start (period_start[0])
    );

    pwm_channel_controller_pwm_gen #(
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) u_gen1 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_duty0        (reg_pwm_gen_1_ch_0_duty_cycle),
        .i_duty1        (reg_pwm_gen_1_ch_1_duty_cycle),
        .i_div          (reg_pwm_gen_1_0_frequency_divider[2*DIV_W-1:DIV_W]),
        .o_level        (w_level[3:2]),
        .o_period_start (period_start[1])
    );

    assign w_sel_all = {reg_out_7_4_pwm_gen_channel, reg_out_3_0_pwm_gen_channel};

    always_comb begin
        w_pwm_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (!reg_en_out[i]) begin
                w_pwm_d[i] = 1'b0;
            end else if (!reg_en_pwm_out[i]) begin
                w_pwm_d[i] = 1'b1;
            end else begin
                case (w_sel_all[2*i +: 2])
                    SEL_G0C0: w_pwm_d[i] = w_level[0];
                    SEL_G0C1: w_pwm_d[i] = w_level[1];
                    SEL_G1C0: w_pwm_d[i] = w_level[2];
                    SEL_G1C1: w_pwm_d[i] = w_level[3];
                    default:  w_pwm_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= w_pwm_d;
        end
    end

endmodule
